// File: rtl/aes_round_tail_if.sv
// rtl/aes_round_tail_if.sv - input/output handshake bundle for the AES round tail stage
interface aes_round_tail_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] state_in;
    logic [DATA_W-1:0] round_key;
    logic              last_round;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] state_out;
    logic              out_last;

    modport slave (
        input  in_valid, state_in, round_key, last_round, out_ready,
        output in_ready, out_valid, state_out, out_last
    );

    modport master (
        output in_valid, state_in, round_key, last_round, out_ready,
        input  in_ready, out_valid, state_out, out_last
    );
endinterface

// File: rtl/aes_round_tail.sv
// rtl/aes_round_tail.sv - ShiftRows/MixColumns/AddRoundKey stage with two-entry elastic output buffer
module aes_round_tail #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_round_tail_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    buf_state_t        state, state_nx;
    logic [DATA_W-1:0] out_data, skid_data;
    logic              out_last_q, skid_last;
    logic              load_out_in, load_out_skid, load_skid;
    logic              in_fire, out_fire;

    logic [7:0]   s_b  [16];
    logic [7:0]   sr_b [16];
    logic [7:0]   mc_b [16];
    logic [127:0] result;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Byte n is s[n%4][n/4]; ShiftRows rotates row r left by r columns.
    for (genvar n = 0; n < 16; n++) begin : g_bytes
        assign s_b[n] = bus.state_in[127-8*n -: 8];
        assign result[127-8*n -: 8] = (bus.last_round ? sr_b[n] : mc_b[n])
                                      ^ bus.round_key[127-8*n -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_cols
        for (genvar r = 0; r < 4; r++) begin : g_rows
            assign sr_b[r+4*c] = s_b[r + 4*((c+r)%4)];
        end
        assign mc_b[4*c]   = xtime(sr_b[4*c]) ^ xtime(sr_b[4*c+1]) ^ sr_b[4*c+1]
                             ^ sr_b[4*c+2] ^ sr_b[4*c+3];
        assign mc_b[4*c+1] = sr_b[4*c] ^ xtime(sr_b[4*c+1]) ^ xtime(sr_b[4*c+2])
                             ^ sr_b[4*c+2] ^ sr_b[4*c+3];
        assign mc_b[4*c+2] = sr_b[4*c] ^ sr_b[4*c+1] ^ xtime(sr_b[4*c+2])
                             ^ xtime(sr_b[4*c+3]) ^ sr_b[4*c+3];
        assign mc_b[4*c+3] = xtime(sr_b[4*c]) ^ sr_b[4*c] ^ sr_b[4*c+1]
                             ^ sr_b[4*c+2] ^ xtime(sr_b[4*c+3]);
    end

    // Both handshake outputs come straight from the state register.
    assign bus.in_ready  = (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign bus.state_out = out_data;
    assign bus.out_last  = out_last_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nx    = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_out_in = 1'b1;
                end else if (in_fire) begin
                    state_nx  = TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_nx      = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_last_q <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_data   <= result;
                out_last_q <= bus.last_round;
            end else if (load_out_skid) begin
                out_data   <= skid_data;
                out_last_q <= skid_last;
            end
            if (load_skid) begin
                skid_data <= result;
                skid_last <= bus.last_round;
            end
        end
    end
endmodule

// File: tb/tb_aes_round_tail.sv
// tb/tb_aes_round_tail.sv - directed and randomized handshake bench for aes_round_tail
module tb_aes_round_tail;
    localparam logic [127:0] R1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] R1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] FR_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
    localparam logic [127:0] FR_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FR_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    aes_round_tail_if bus();

    aes_round_tail dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_tail(input logic [127:0] st, input logic [127:0] key,
                                              input logic last);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   o [4][4];
        logic [7:0]   acc;
        logic [7:0]   cf;
        logic [127:0] res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = st[127-8*(r+4*c) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = m[r][(c+r)%4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (last) begin
                    o[r][c] = t[r][c];
                end else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++) begin
                        case ((k - r + 4) % 4)
                            0:       cf = 8'h02;
                            1:       cf = 8'h03;
                            default: cf = 8'h01;
                        endcase
                        acc = acc ^ gmul(cf, t[k][c]);
                    end
                    o[r][c] = acc;
                end
            end
        end
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127-8*(r+4*c) -: 8] = o[r][c] ^ key[127-8*(r+4*c) -: 8];
        return res;
    endfunction

    task automatic check_word(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k,
                         input logic l, input logic rdy);
        bus.in_valid   = v;
        bus.state_in   = s;
        bus.round_key  = k;
        bus.last_round = l;
        bus.out_ready  = rdy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        exp_t         e;
        logic [127:0] k;
        logic [127:0] c_exp;
        logic [31:0]  w;
        logic         nv, nr, nl;
        logic [127:0] ns, nk;
        int           got, sent, cyc;

        drive(1'b0, '0, '0, 1'b0, 1'b0);

        #3;
        check_bit ("rst_out_valid", bus.out_valid, 1'b0);
        check_bit ("rst_in_ready",  bus.in_ready,  1'b1);
        check_word("rst_state_out", bus.state_out, 128'd0);
        check_bit ("rst_out_last",  bus.out_last,  1'b0);

        // Round 1 vector
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, R1_IN, R1_KEY, 1'b0, 1'b1);
        @(negedge clk);
        check_bit ("r1_valid", bus.out_valid, 1'b1);
        check_word("r1_data",  bus.state_out, R1_OUT);
        check_bit ("r1_last",  bus.out_last,  1'b0);
        drive(1'b1, FR_IN, FR_KEY, 1'b1, 1'b1);
        @(negedge clk);
        check_bit ("fr_valid", bus.out_valid, 1'b1);
        check_word("fr_data",  bus.state_out, FR_OUT);
        check_bit ("fr_last",  bus.out_last,  1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        check_bit ("drain_valid", bus.out_valid, 1'b0);

        // Backpressure: three inputs, output stalled
        c_exp = ref_tail(R1_IN, ~R1_KEY, 1'b0);
        drive(1'b1, R1_IN, R1_KEY, 1'b0, 1'b0);
        @(negedge clk);
        check_bit ("bp_a_valid", bus.out_valid, 1'b1);
        check_word("bp_a_data",  bus.state_out, R1_OUT);
        check_bit ("bp_ready1",  bus.in_ready,  1'b1);
        drive(1'b1, FR_IN, FR_KEY, 1'b1, 1'b0);
        @(negedge clk);
        check_bit ("bp_ready2",  bus.in_ready,  1'b0);
        check_word("bp_hold1",   bus.state_out, R1_OUT);
        drive(1'b1, R1_IN, ~R1_KEY, 1'b0, 1'b0);
        @(negedge clk);
        check_bit ("bp_ready3",  bus.in_ready,  1'b0);
        check_bit ("bp_hold_v",  bus.out_valid, 1'b1);
        check_word("bp_hold2",   bus.state_out, R1_OUT);
        check_bit ("bp_hold_l",  bus.out_last,  1'b0);
        drive(1'b1, R1_IN, ~R1_KEY, 1'b0, 1'b1);
        @(negedge clk);
        check_word("bp_b_data",  bus.state_out, FR_OUT);
        check_bit ("bp_b_last",  bus.out_last,  1'b1);
        check_bit ("bp_ready4",  bus.in_ready,  1'b1);
        @(negedge clk);
        check_bit ("bp_c_valid", bus.out_valid, 1'b1);
        check_word("bp_c_data",  bus.state_out, c_exp);
        check_bit ("bp_c_last",  bus.out_last,  1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        check_bit ("bp_empty",   bus.out_valid, 1'b0);

        // Streaming: 16 back-to-back transfers with varying keys
        q.delete();
        for (int i = 0; i < 17; i++) begin
            if (i > 0) begin
                check_bit("stream_valid", bus.out_valid, 1'b1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check_word("stream_data", bus.state_out, e.data);
                    check_bit ("stream_last", bus.out_last,  e.last);
                end
            end
            if (i < 16) begin
                check_bit("stream_ready", bus.in_ready, 1'b1);
                w = i * 32'h9e3779b9;
                k = R1_KEY ^ {w, ~w, w, w};
                e.data = ref_tail(R1_IN, k, 1'b0);
                e.last = 1'b0;
                q.push_back(e);
                drive(1'b1, R1_IN, k, 1'b0, 1'b1);
            end else begin
                drive(1'b0, '0, '0, 1'b0, 1'b1);
            end
            @(negedge clk);
        end
        check_bit("stream_idle", bus.out_valid, 1'b0);

        // Random valid/ready with scoreboard
        q.delete();
        got  = 0;
        sent = 0;
        cyc  = 0;
        while (got < 1000 && cyc < 20000) begin
            cyc++;
            nv = ($urandom_range(0, 3) != 0) && (sent < 1000);
            nr = ($urandom_range(0, 2) != 0);
            ns = {$urandom, $urandom, $urandom, $urandom};
            nk = {$urandom, $urandom, $urandom, $urandom};
            nl = 1'($urandom_range(0, 1));
            if (bus.out_valid && nr) begin
                if (q.size() == 0) begin
                    check_bit("rand_spurious", bus.out_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    check_word("rand_data", bus.state_out, e.data);
                    check_bit ("rand_last", bus.out_last,  e.last);
                end
                got++;
            end
            if (nv && bus.in_ready) begin
                e.data = ref_tail(ns, nk, nl);
                e.last = nl;
                q.push_back(e);
                sent++;
            end
            drive(nv, ns, nk, nl, nr);
            @(negedge clk);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check_bit("rand_complete", (got == 1000) && (q.size() == 0), 1'b1);
        @(negedge clk);
        check_bit("rand_idle", bus.out_valid, 1'b0);

        // Asynchronous reset while both registers are full
        drive(1'b1, FR_IN, FR_KEY, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, FR_IN, ~FR_KEY, 1'b1, 1'b0);
        @(negedge clk);
        check_bit("two_ready", bus.in_ready,  1'b0);
        check_bit("two_valid", bus.out_valid, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit ("arst_valid", bus.out_valid, 1'b0);
        check_bit ("arst_ready", bus.in_ready,  1'b1);
        check_word("arst_data",  bus.state_out, 128'd0);
        check_bit ("arst_last",  bus.out_last,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, R1_IN, R1_KEY, 1'b0, 1'b1);
        @(negedge clk);
        check_bit ("post_valid", bus.out_valid, 1'b1);
        check_word("post_data",  bus.state_out, R1_OUT);
        check_bit ("post_last",  bus.out_last,  1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        check_bit ("post_empty", bus.out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/aes_round_tail.md
Name: aes_round_tail

Overview:
- Registered stage directly downstream of sub_bytes in the AES-128 encryption datapath.
- Consumes the SubBytes output and applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Outputs the next round state over a valid/ready handshake.
- A two-entry elastic buffer (output register plus skid register) gives full throughput under backpressure without a combinational ready path from output to input.

Parameters:
- DATA_W, 128, state and round-key width; fixed at 128, any other value is unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  state_in, round_key and last_round are valid.
- in_ready  output  1  stage can accept input this cycle.
- state_in  input  128  post-SubBytes state.
- round_key  input  128  round key for this round.
- last_round  input  1  1 = round 10, bypass MixColumns.
- out_valid  output  1  state_out is valid.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  ShiftRows/MixColumns/AddRoundKey result.
- out_last  output  1  last_round flag carried with the data.

Behaviour:
- Byte order:
  - byte n (n = 0..15) sits at [127-8n -: 8].
  - FIPS-197 column-major: s[r][c] = byte r+4c.
- ShiftRows: s'[r][c] = s[r][(c+r) mod 4].
- MixColumns per column, GF(2^8) modulo 0x11B:
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00).
  - Matrix rows: 02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02.
- last_round = 1: result = ShiftRows(state_in) ^ round_key, with no MixColumns.
- Datapath is combinational from the input; the result is captured on accept.
- Latency: an input accepted at edge k gives out_valid = 1 after edge k when the output register is empty.
- Handshake:
  - A transfer occurs when valid & ready are both high at a rising edge.
  - in_ready = !skid_full; it is registered and independent of out_ready in the same cycle.
  - out_valid, state_out and out_last stay stable while out_valid & !out_ready.
- Buffer states: EMPTY (neither register full), ONE (output register full), TWO (output and skid full).
  - EMPTY + in_fire -> ONE.
  - ONE + in_fire & !out_fire -> TWO; the new result goes into skid.
  - ONE + in_fire & out_fire -> ONE; the new result goes into the output register.
  - ONE + out_fire & !in_fire -> EMPTY.
  - TWO + out_fire -> ONE; skid moves to the output register. in_fire is impossible in TWO because in_ready = 0.
- Ordering: strict FIFO, no reordering or dropping; out_last always travels with its own data.
- Reset (asynchronous, while rst_n = 0):
  - out_valid = 0, state_out = 0, out_last = 0, in_ready = 1, skid empty.
  - Reset mid-operation discards all buffered data.
  - First accept occurs at the first rising edge after rst_n deasserts with in_valid = 1.
- X-handling: state_in, round_key and last_round are ignored when in_valid = 0.

Test Plan:
- FIPS-197 App. B round 1: state_in = d42711aee0bf98f1b8b45de51e415230, round_key = a0fafe1788542cb123a339392a6c7605, last_round = 0, out_ready = 1 -> one cycle later out_valid = 1, state_out = a49c7ff2689f352b6b5bea43026a5049, out_last = 0.
- Final round: state_in = e9098972cb31075f3d327d94af2e2cb5, round_key = d014f9a8c9ee2589e13f0cc8b6630ca6, last_round = 1 -> state_out = 3925841d02dc09fbdc118597196a0b32, out_last = 1.
- Backpressure: hold out_ready = 0 and present 3 back-to-back inputs -> first two accepted, in_ready = 0 after the second, state_out held stable. Release out_ready -> both results emerge in order, in_ready returns to 1, third input accepted afterwards.
- Streaming: in_valid = 1 and out_ready = 1 for 16 cycles with the round-1 vector and round_key varied -> 16 outputs on consecutive cycles, no bubbles, each equal to the reference-model result.
- Random valid/ready toggling over 1000 transactions with a scoreboard -> no loss, duplication or reordering, and out_last matches its data.
- Reset: assert rst_n = 0 asynchronously while in state TWO -> out_valid drops immediately, in_ready = 1. After release, the round-1 vector gives the correct result with no stale data.
